// File: rtl/matmul_ctrl.sv
// Sequencer for a small systolic matrix-multiply engine.
// The sequence is: clear the accumulators, feed K operand slices, and wait
// out the array skew. It then writes N result rows to the chosen scratchpad
// target, honouring backpressure, and finally pulses done.
module matmul_ctrl #(
  parameter  int unsigned BUS_WIDTH   = 64,
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  parameter  int unsigned SP_NTARGETS = 4,
  localparam int unsigned DIMW        = $clog2(MAX_DIM),
  localparam int unsigned CNTW        = $clog2(2 * MAX_DIM),
  localparam int unsigned TGTW        = $clog2(SP_NTARGETS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [DIMW-1:0] dim_n_i,
  input  logic [DIMW-1:0] dim_k_i,
  input  logic [DIMW-1:0] dim_m_i,
  input  logic [TGTW-1:0] sp_tgt_i,
  input  logic            wr_ready_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            clr_o,
  output logic            feed_en_o,
  output logic [DIMW-1:0] feed_k_o,
  output logic            wr_en_o,
  output logic [DIMW-1:0] wr_row_o,
  output logic [TGTW-1:0] wr_tgt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_WB,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DIMW-1:0] dim_n_q, dim_n_d;
  logic [DIMW-1:0] dim_k_q, dim_k_d;
  logic [DIMW-1:0] dim_m_q, dim_m_d;
  logic [TGTW-1:0] tgt_q, tgt_d;

  // The last drain cycle is reached after N+M-1 cycles, so the counter
  // stops at (N-1)+(M-1). That value fits CNTW bits for any MAX_DIM.
  logic [CNTW-1:0] drain_last;
  assign drain_last = CNTW'(dim_n_q) + CNTW'(dim_m_q);

  // State, phase counter and operation descriptor registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dim_n_q <= '0;
      dim_k_q <= '0;
      dim_m_q <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dim_n_q <= dim_n_d;
      dim_k_q <= dim_k_d;
      dim_m_q <= dim_m_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state logic. The counter restarts at 0 on every state change.
  // Dims and target only load in IDLE, so they stay frozen while busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dim_n_d = dim_n_q;
    dim_k_d = dim_k_q;
    dim_m_d = dim_m_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = S_CLEAR;
          dim_n_d = dim_n_i;
          dim_k_d = dim_k_i;
          dim_m_d = dim_m_i;
          tgt_d   = sp_tgt_i;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        if (cnt_q == CNTW'(dim_k_q)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == drain_last) begin
          state_d = S_WB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        if (wr_ready_i) begin
          if (cnt_q == CNTW'(dim_n_q)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded purely from registered state, counter and target.
  always_comb begin
    busy_o    = (state_q == S_CLEAR) || (state_q == S_FEED) ||
                (state_q == S_DRAIN) || (state_q == S_WB);
    done_o    = (state_q == S_DONE);
    clr_o     = (state_q == S_CLEAR);
    feed_en_o = (state_q == S_FEED);
    wr_en_o   = (state_q == S_WB);
    feed_k_o  = feed_en_o ? cnt_q[DIMW-1:0] : '0;
    wr_row_o  = wr_en_o ? cnt_q[DIMW-1:0] : '0;
    wr_tgt_o  = (busy_o || done_o) ? tgt_q : '0;
  end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl built with MAX_DIM=4.
// The reference model lays out the expected per-cycle output timeline of
// one operation from N, K, M, the target and the ready pattern.
module tb_matmul_ctrl;

  localparam int BW   = 128;
  localparam int DW   = 32;
  localparam int DIMW = 2;
  localparam int TGTW = 2;
  localparam int MAXL = 256;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            clr;
    logic            fen;
    logic [DIMW-1:0] fk;
    logic            wen;
    logic [DIMW-1:0] row;
    logic [TGTW-1:0] tgt;
  } obs_t;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic [DIMW-1:0] dim_n_i = '0;
  logic [DIMW-1:0] dim_k_i = '0;
  logic [DIMW-1:0] dim_m_i = '0;
  logic [TGTW-1:0] sp_tgt_i = '0;
  logic            wr_ready_i = 1'b0;
  logic            busy_o, done_o, clr_o, feed_en_o, wr_en_o;
  logic [DIMW-1:0] feed_k_o, wr_row_o;
  logic [TGTW-1:0] wr_tgt_o;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_a [MAXL];
  bit   rdy   [MAXL];

  matmul_ctrl #(
    .BUS_WIDTH  (BW),
    .DATA_WIDTH (DW),
    .SP_NTARGETS(4)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .dim_n_i   (dim_n_i),
    .dim_k_i   (dim_k_i),
    .dim_m_i   (dim_m_i),
    .sp_tgt_i  (sp_tgt_i),
    .wr_ready_i(wr_ready_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .clr_o     (clr_o),
    .feed_en_o (feed_en_o),
    .feed_k_o  (feed_k_o),
    .wr_en_o   (wr_en_o),
    .wr_row_o  (wr_row_o),
    .wr_tgt_o  (wr_tgt_o)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input bit busy, done, clr, fen, input int fk,
                              input bit wen, input int row, input int tgt);
    obs_t o;
    o.busy = busy; o.done = done; o.clr = clr; o.fen = fen;
    o.fk = DIMW'(fk); o.wen = wen; o.row = DIMW'(row); o.tgt = TGTW'(tgt);
    return o;
  endfunction

  // Timeline: start in cycle 0, clear in 1, K feed cycles, N+M-1 drain
  // cycles, then one row per cycle advancing only when ready, then done.
  function automatic void build(input int nd, kd, md, tgt, rst_c,
                                input bit hold, input int len);
    int n, k, m, c, row;
    n = nd + 1; k = kd + 1; m = md + 1;
    for (int i = 0; i < len; i++) exp_a[i] = '0;
    exp_a[1] = mk(1, 0, 1, 0, 0, 0, 0, tgt);
    for (int i = 0; i < k; i++) exp_a[2 + i] = mk(1, 0, 0, 1, i, 0, 0, tgt);
    for (int i = 0; i < n + m - 1; i++) exp_a[2 + k + i] = mk(1, 0, 0, 0, 0, 0, 0, tgt);
    c = 2 + k + n + m - 1;
    row = 0;
    while (row < n && c < len) begin
      exp_a[c] = mk(1, 0, 0, 0, 0, 1, row, tgt);
      if (rdy[c]) row++;
      c++;
    end
    if (c < len) exp_a[c] = mk(0, 1, 0, 0, 0, 0, 0, tgt);
    if (hold && c + 2 < len) exp_a[c + 2] = mk(1, 0, 1, 0, 0, 0, 0, tgt);
    if (rst_c >= 0)
      for (int i = rst_c + 1; i < len; i++) exp_a[i] = '0;
  endfunction

  function automatic void rdy_fill(input bit v);
    for (int i = 0; i < MAXL; i++) rdy[i] = v;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_seq();
    @(posedge clk); #1;
    rst_ni = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check("reset", {busy_o, done_o, clr_o, feed_en_o, feed_k_o, wr_en_o, wr_row_o, wr_tgt_o}, '0);
  endtask

  task automatic run_op(input string name, input int nd, kd, md, tgt,
                        input int pulse_c, rst_c, input bit hold, input int len);
    build(nd, kd, md, tgt, rst_c, hold, len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      start_i = hold || (c == 0) || (c == pulse_c);
      if (c == 0 || hold) begin
        dim_n_i = DIMW'(nd); dim_k_i = DIMW'(kd); dim_m_i = DIMW'(md); sp_tgt_i = TGTW'(tgt);
      end else if (c == pulse_c) begin
        dim_n_i = ~DIMW'(nd); dim_k_i = ~DIMW'(kd); dim_m_i = ~DIMW'(md); sp_tgt_i = ~TGTW'(tgt);
      end else begin
        dim_n_i = DIMW'($urandom); dim_k_i = DIMW'($urandom);
        dim_m_i = DIMW'($urandom); sp_tgt_i = TGTW'($urandom);
      end
      rst_ni = (c == rst_c) ? 1'b0 : 1'b1;
      wr_ready_i = rdy[c];
      @(negedge clk);
      check($sformatf("%s cyc%0d", name, c),
            {busy_o, done_o, clr_o, feed_en_o, feed_k_o, wr_en_o, wr_row_o, wr_tgt_o},
            exp_a[c]);
    end
    #1;
    start_i = 1'b0;
    rst_ni = 1'b1;
  endtask

  initial begin
    int nd, kd, md, tg;
    reset_seq();

    rdy_fill(1);
    run_op("nominal", 1, 2, 1, 2, -1, -1, 0, 13);

    rdy_fill(1);
    for (int i = 8; i <= 10; i++) rdy[i] = 0;
    run_op("backpressure", 1, 2, 1, 1, -1, -1, 0, 16);

    rdy_fill(1);
    run_op("min", 0, 0, 0, 3, -1, -1, 0, 8);

    rdy_fill(1);
    run_op("max", 3, 3, 3, 2, -1, -1, 0, 20);

    rdy_fill(1);
    run_op("start_busy", 1, 2, 1, 1, 3, -1, 0, 14);

    rdy_fill(1);
    run_op("reset_mid", 1, 2, 1, 3, -1, 6, 0, 20);
    run_op("after_reset", 1, 2, 1, 2, -1, -1, 0, 13);

    rdy_fill(1);
    run_op("hold_start", 1, 2, 1, 1, -1, -1, 1, 13);
    reset_seq();

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < MAXL; i++) rdy[i] = (i >= 40) || ($urandom_range(0, 9) < 7);
      nd = $urandom_range(0, 3); kd = $urandom_range(0, 3);
      md = $urandom_range(0, 3); tg = $urandom_range(0, 3);
      run_op($sformatf("rand%0d", t), nd, kd, md, tg, -1, -1, 0, 64);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  BUS_WIDTH, 64, scratchpad row width in bits.
  DATA_WIDTH, 32, element width in bits.
  MAX_DIM, BUS_WIDTH/DATA_WIDTH, maximum matrix dimension.
  SP_NTARGETS, 4, number of scratchpad targets.
REQ-002 Derived widths SHALL be DIMW = $clog2(MAX_DIM), CNTW = $clog2(2*MAX_DIM), TGTW = $clog2(SP_NTARGETS).
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
  clk_i, in, 1, single clock; all logic rising-edge.
  rst_ni, in, 1, synchronous active-low reset.
  start_i, in, 1, start request from control register.
  dim_n_i, in, DIMW, rows of A minus 1.
  dim_k_i, in, DIMW, cols of A / rows of B minus 1.
  dim_m_i, in, DIMW, cols of B minus 1.
  sp_tgt_i, in, TGTW, scratchpad target for the result.
  wr_ready_i, in, 1, scratchpad accepts the current row write.
  busy_o, out, 1, operation in progress.
  done_o, out, 1, one-cycle completion pulse.
  clr_o, out, 1, clear systolic-array accumulators.
  feed_en_o, out, 1, operand feed strobe to the array.
  feed_k_o, out, DIMW, operand index k being fed.
  wr_en_o, out, 1, result row write request.
  wr_row_o, out, DIMW, result row index.
  wr_tgt_o, out, TGTW, latched scratchpad target.

Function
REQ-004 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN, WB and DONE; N=dim_n_i+1, K=dim_k_i+1, M=dim_m_i+1.
REQ-005 In IDLE, start_i=1 SHALL latch dims and sp_tgt_i and move to CLEAR on the next edge; start_i in any other state SHALL be ignored.
REQ-006 CLEAR SHALL last exactly 1 cycle with clr_o=1, then move to FEED.
REQ-007 FEED SHALL last exactly K cycles with feed_en_o=1 and feed_k_o=0,1,...,K-1, then move to DRAIN.
REQ-008 DRAIN SHALL last exactly N+M-1 cycles (array skew) with all strobes low, then move to WB.
REQ-009 In WB, wr_en_o SHALL be 1 and wr_row_o SHALL start at 0.
REQ-010 In WB, a row is accepted when wr_en_o and wr_ready_i are both 1; wr_row_o SHALL increment only on accept.
REQ-011 In WB, wr_en_o and wr_row_o SHALL be held stable while wr_ready_i=0, with no timeout.
REQ-012 Accept of row N-1 SHALL move to DONE; DONE SHALL last 1 cycle with done_o=1, then move to IDLE.
REQ-013 busy_o SHALL be 1 in CLEAR, FEED, DRAIN and WB, and 0 in IDLE and DONE.
REQ-014 wr_tgt_o SHALL present the latched target from CLEAR through DONE; latched dims SHALL NOT change while busy_o=1.
REQ-015 All outputs SHALL be registered or decoded from state and counter only, with no combinational path from inputs to outputs.
REQ-016 Total latency from the start_i cycle to done_o SHALL be 1+K+(N+M-1)+N+stall_cycles+1 cycles.
REQ-017 The phase counter SHALL be CNTW bits, reset to 0 on every state entry, and SHALL never wrap within a state.
REQ-018 In the 1x1x1 case the sequence SHALL be CLEAR, FEED 1 cycle, DRAIN 1 cycle, WB 1 row, DONE.
REQ-019 start_i held high continuously SHALL start a new operation only from IDLE, i.e. one cycle after done_o.

Reset
REQ-020 rst_ni=0 at a clock edge SHALL force IDLE, clear counters and latched fields, and drive every output to 0 from the next cycle, in any state.
REQ-021 After reset is released, the block SHALL require a fresh start_i; an interrupted operation SHALL NOT resume or complete.

Verification
REQ-022 The bench SHALL cover the nominal case: N=2,K=3,M=2, wr_ready_i=1, start at cycle 0 -> clr_o at 1, feed at 2-4 with k=0,1,2, drain at 5-7, wr rows 0,1 at 8-9, done_o at 10.
REQ-023 The bench SHALL cover write backpressure: same case with wr_ready_i=0 at cycles 8-10 -> row 0 held through cycle 11, row 1 at 12, done_o at 13.
REQ-024 The bench SHALL cover the minimum size: all dims 0 -> clr_o at 1, feed at 2, drain at 3, wr row 0 at 4, done_o at 5.
REQ-025 The bench SHALL cover the maximum size: all dims MAX_DIM-1=3 -> 4 feed cycles, 7 drain cycles, 4 writes, done_o at cycle 17.
REQ-026 The bench SHALL cover start while busy: start_i pulsed in FEED with different dims and target -> timing and wr_tgt_o unchanged, and no second operation.
REQ-027 The bench SHALL cover reset mid-operation: rst_ni=0 for one cycle during DRAIN -> all outputs 0 next cycle, done_o never asserted, and a later start runs the nominal timing.
